// File: rtl/padctrl_boot_seq_if.sv
// APB3 signal bundle used on both sides of the pad-control boot sequencer.
// The master modport drives the request; the slave modport returns the response.
interface padctrl_boot_seq_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [19:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/padctrl_boot_seq.sv
// Replays a fixed table of APB writes into pad control after reset or on request,
// then passes fabric APB traffic straight through. Reports completion and first error.
module padctrl_boot_seq #(
  parameter int N_ENTRIES = 4,
  parameter int W_IDX     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_ENTRIES*20-1:0] table_addr,
  input  logic [N_ENTRIES*32-1:0] table_data,
  input  logic                   restart,
  output logic                   done,
  output logic                   err,
  output logic [W_IDX-1:0]       err_idx,
  padctrl_boot_seq_if.slave      apbs,
  padctrl_boot_seq_if.master     apbm
);

  typedef enum logic [2:0] {START, B_SETUP, B_ACCESS, RESYNC, PASS} state_t;

  state_t           state, state_nxt;
  logic [W_IDX-1:0] idx, idx_nxt, err_idx_nxt;
  logic             done_nxt, err_nxt;
  logic             restart_pend, restart_pend_nxt;
  logic             last_entry;
  logic [19:0]      entry_addr;
  logic [31:0]      entry_data;

  // Constant-slice mux keeps the table select free of width-mixing arithmetic.
  always_comb begin
    entry_addr = '0;
    entry_data = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (idx == W_IDX'(i)) begin
        entry_addr = table_addr[20*i +: 20];
        entry_data = table_data[32*i +: 32];
      end
    end
  end

  assign last_entry = (idx == W_IDX'(N_ENTRIES - 1));

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= START;
      idx          <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_idx      <= '0;
      restart_pend <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
      err_idx      <= err_idx_nxt;
      restart_pend <= restart_pend_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    done_nxt         = done;
    err_nxt          = err;
    err_idx_nxt      = err_idx;
    restart_pend_nxt = restart_pend;

    apbm.psel    = 1'b0;
    apbm.penable = 1'b0;
    apbm.pwrite  = 1'b0;
    apbm.paddr   = '0;
    apbm.pwdata  = '0;
    apbs.prdata  = '0;
    apbs.pready  = 1'b0;
    apbs.pslverr = 1'b0;

    if (restart && done) restart_pend_nxt = 1'b1;

    unique case (state)
      START: state_nxt = B_SETUP;

      B_SETUP: begin
        apbm.psel   = 1'b1;
        apbm.pwrite = 1'b1;
        apbm.paddr  = entry_addr;
        apbm.pwdata = entry_data;
        state_nxt   = B_ACCESS;
      end

      B_ACCESS: begin
        apbm.psel    = 1'b1;
        apbm.penable = 1'b1;
        apbm.pwrite  = 1'b1;
        apbm.paddr   = entry_addr;
        apbm.pwdata  = entry_data;
        if (apbm.pready) begin
          if (apbm.pslverr && !err) begin
            err_nxt     = 1'b1;
            err_idx_nxt = idx;
          end
          if (last_entry) begin
            done_nxt = 1'b1;
            // Pad control never saw the fabric's setup phase if it is already in access.
            state_nxt = (apbs.psel && apbs.penable) ? RESYNC : PASS;
          end else begin
            idx_nxt   = idx + W_IDX'(1);
            state_nxt = B_SETUP;
          end
        end
      end

      RESYNC: begin
        apbm.psel   = 1'b1;
        apbm.pwrite = apbs.pwrite;
        apbm.paddr  = apbs.paddr;
        apbm.pwdata = apbs.pwdata;
        state_nxt   = PASS;
      end

      PASS: begin
        apbm.psel    = apbs.psel;
        apbm.penable = apbs.penable;
        apbm.pwrite  = apbs.pwrite;
        apbm.paddr   = apbs.paddr;
        apbm.pwdata  = apbs.pwdata;
        apbs.prdata  = apbm.prdata;
        apbs.pready  = apbm.pready;
        apbs.pslverr = apbm.pslverr;
        // Leave only between fabric transfers so an in-flight one always completes.
        if (restart_pend && !apbs.psel) begin
          done_nxt         = 1'b0;
          err_nxt          = 1'b0;
          err_idx_nxt      = '0;
          idx_nxt          = '0;
          restart_pend_nxt = 1'b0;
          state_nxt        = B_SETUP;
        end
      end

      default: state_nxt = START;
    endcase
  end

endmodule

// File: tb/tb_padctrl_boot_seq.sv
// Self-checking bench for padctrl_boot_seq: pad-control responder model, transfer
// monitor feeding a scoreboard, and one task per scenario.
module tb_padctrl_boot_seq;

  localparam int N_ENTRIES = 3;
  localparam int W_IDX     = 4;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
    logic        write;
  } xfer_t;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
    logic        write;
    logic        setup_ok;
    logic        stable;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic done, err;
  logic [W_IDX-1:0] err_idx;

  logic [N_ENTRIES*20-1:0] table_addr = {20'h00008, 20'h00004, 20'h00000};
  logic [N_ENTRIES*32-1:0] table_data = {32'h33, 32'h22, 32'h11};

  padctrl_boot_seq_if apbs_if ();
  padctrl_boot_seq_if apbm_if ();

  padctrl_boot_seq #(.N_ENTRIES(N_ENTRIES), .W_IDX(W_IDX)) dut (
    .clk        (clk),
    .rst        (rst),
    .table_addr (table_addr),
    .table_data (table_data),
    .restart    (restart),
    .done       (done),
    .err        (err),
    .err_idx    (err_idx),
    .apbs       (apbs_if),
    .apbm       (apbm_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  xfer_t exp_q[$];
  obs_t  obs_q[$];

  // Pad-control responder: optional wait states on one address, per-entry error mask.
  logic [19:0] ws_addr  = 20'hFFFFF;
  int          ws_n     = 0;
  logic [3:0]  err_mask = '0;
  int          ws_cnt;

  function automatic logic [31:0] rdata_of(input logic [19:0] a);
    return {12'hC0D, a};
  endfunction

  assign apbm_if.pready  = apbm_if.psel && apbm_if.penable &&
                           ((apbm_if.paddr != ws_addr) || (ws_cnt >= ws_n));
  assign apbm_if.pslverr = apbm_if.pready && err_mask[apbm_if.paddr[3:2]];
  assign apbm_if.prdata  = apbm_if.pready ? rdata_of(apbm_if.paddr) : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) ws_cnt <= 0;
    else if (apbm_if.psel && apbm_if.penable && !apbm_if.pready) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  // Monitor: records every completed downstream transfer with protocol observations.
  logic        prev_setup = 1'b0, prev_wait = 1'b0;
  logic [19:0] prev_paddr;
  logic [31:0] prev_pwdata;
  logic        mon_setup_ok, mon_stable;

  always @(negedge clk) begin
    if (rst) begin
      prev_setup = 1'b0;
      prev_wait  = 1'b0;
    end else begin
      if (apbm_if.psel && apbm_if.penable) begin
        if (!prev_wait) begin
          mon_setup_ok = prev_setup;
          mon_stable   = 1'b1;
        end else if (apbm_if.paddr !== prev_paddr || apbm_if.pwdata !== prev_pwdata) begin
          mon_stable = 1'b0;
        end
        if (apbm_if.pready)
          obs_q.push_back('{addr: apbm_if.paddr, data: apbm_if.pwdata, write: apbm_if.pwrite,
                            setup_ok: mon_setup_ok, stable: mon_stable});
      end
      prev_setup  = apbm_if.psel && !apbm_if.penable;
      prev_wait   = apbm_if.psel && apbm_if.penable && !apbm_if.pready;
      prev_paddr  = apbm_if.paddr;
      prev_pwdata = apbm_if.pwdata;
    end
  end

  task automatic push_boot();
    for (int i = 0; i < N_ENTRIES; i++)
      exp_q.push_back('{addr: table_addr[20*i +: 20], data: table_data[32*i +: 32], write: 1'b1});
  endtask

  task automatic drain(input string name);
    xfer_t e;
    obs_t  o;
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s xfer_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.write !== e.write || (e.write && o.data !== e.data) ||
          o.setup_ok !== 1'b1 || o.stable !== 1'b1) begin
        errors++;
        $display("FAIL %s xfer: got addr=%h data=%h wr=%b setup=%b stable=%b expected addr=%h data=%h wr=%b setup=1 stable=1",
                 name, o.addr, o.data, o.write, o.setup_ok, o.stable, e.addr, e.data, e.write);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_boot();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string name);
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 60);
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_cyc);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({apbm_if.psel, apbm_if.penable, apbm_if.pwrite, apbm_if.paddr, apbm_if.pwdata} !== '0) begin
      errors++;
      $display("FAIL reset apbm: got psel=%b pen=%b pwr=%b addr=%h wdata=%h expected all 0",
               apbm_if.psel, apbm_if.penable, apbm_if.pwrite, apbm_if.paddr, apbm_if.pwdata);
    end
    checks++;
    if ({done, err, err_idx} !== '0) begin
      errors++;
      $display("FAIL reset status: got done=%b err=%b err_idx=%0d expected 0", done, err, err_idx);
    end
    checks++;
    if ({apbs_if.pready, apbs_if.pslverr, apbs_if.prdata} !== '0) begin
      errors++;
      $display("FAIL reset apbs: got pready=%b pslverr=%b prdata=%h expected 0",
               apbs_if.pready, apbs_if.pslverr, apbs_if.prdata);
    end
  endtask

  task automatic test_boot_zero_ws();
    err_mask = '0; ws_addr = 20'hFFFFF; ws_n = 0;
    apply_reset();
    wait_done(2*N_ENTRIES + 1, "boot_zero_ws");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL boot_zero_ws err: got %b expected 0", err);
    end
    drain("boot_zero_ws");
  endtask

  task automatic test_wait_states();
    err_mask = '0; ws_addr = 20'h00004; ws_n = 2;
    apply_reset();
    wait_done(9, "wait_states");
    drain("wait_states");
  endtask

  task automatic test_error_capture();
    err_mask = 4'b0110; ws_addr = 20'hFFFFF; ws_n = 0;
    apply_reset();
    wait_done(7, "error_capture");
    checks++;
    if (err !== 1'b1 || err_idx !== W_IDX'(1)) begin
      errors++;
      $display("FAIL error_capture status: got err=%b err_idx=%0d expected err=1 err_idx=1", err, err_idx);
    end
    drain("error_capture");
    err_mask = '0;
  endtask

  task automatic test_fabric_during_boot();
    int   cyc;
    logic stalled_ok = 1'b1;
    err_mask = '0; ws_addr = 20'hFFFFF; ws_n = 0;
    apply_reset();
    @(posedge clk); #1;
    cyc = 1;
    apbs_if.psel = 1'b1; apbs_if.pwrite = 1'b0; apbs_if.paddr = 20'h00004;
    exp_q.push_back('{addr: 20'h00004, data: 32'h0, write: 1'b0});
    @(posedge clk); #1;
    cyc = 2;
    apbs_if.penable = 1'b1;
    while (!done && cyc < 40) begin
      if (apbs_if.pready !== 1'b0) stalled_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (stalled_ok !== 1'b1 || cyc !== 7) begin
      errors++;
      $display("FAIL fabric_boot stall: got stalled_ok=%b done_cycle=%0d expected 1 and 7", stalled_ok, cyc);
    end
    checks++;
    if (apbm_if.psel !== 1'b1 || apbm_if.penable !== 1'b0 || apbm_if.paddr !== 20'h00004 ||
        apbm_if.pwrite !== 1'b0 || apbs_if.pready !== 1'b0) begin
      errors++;
      $display("FAIL fabric_boot resync: got psel=%b pen=%b addr=%h pwr=%b s_pready=%b expected 1 0 00004 0 0",
               apbm_if.psel, apbm_if.penable, apbm_if.paddr, apbm_if.pwrite, apbs_if.pready);
    end
    @(posedge clk); #1;
    checks++;
    if (apbs_if.pready !== 1'b1 || apbs_if.prdata !== rdata_of(20'h00004) || apbm_if.penable !== 1'b1) begin
      errors++;
      $display("FAIL fabric_boot pass: got pready=%b prdata=%h m_pen=%b expected 1 %h 1",
               apbs_if.pready, apbs_if.prdata, apbm_if.penable, rdata_of(20'h00004));
    end
    @(posedge clk); #1;
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0;
    @(posedge clk); #1;
    drain("fabric_boot");
  endtask

  task automatic test_restart();
    int n = 0;
    err_mask = 4'b0100; ws_addr = 20'hFFFFF; ws_n = 0;
    apply_reset();
    wait_done(7, "restart_first_boot");
    checks++;
    if (err !== 1'b1 || err_idx !== W_IDX'(2)) begin
      errors++;
      $display("FAIL restart pre_err: got err=%b err_idx=%0d expected 1 2", err, err_idx);
    end
    drain("restart_first_boot");
    err_mask = '0; ws_addr = 20'h00010; ws_n = 3;
    @(posedge clk); #1;
    apbs_if.psel = 1'b1; apbs_if.pwrite = 1'b1; apbs_if.paddr = 20'h00010; apbs_if.pwdata = 32'hDEAD_BEEF;
    exp_q.push_back('{addr: 20'h00010, data: 32'hDEAD_BEEF, write: 1'b1});
    push_boot();
    @(posedge clk); #1;
    apbs_if.penable = 1'b1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    while (!apbs_if.pready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (apbs_if.pready !== 1'b1 || done !== 1'b1 || n !== 2) begin
      errors++;
      $display("FAIL restart fabric_complete: got pready=%b done=%b waits=%0d expected 1 1 2", apbs_if.pready, done, n);
    end
    @(posedge clk); #1;
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || err_idx !== '0) begin
      errors++;
      $display("FAIL restart cleared: got done=%b err=%b err_idx=%0d expected 0 0 0", done, err, err_idx);
    end
    wait_done(2*N_ENTRIES, "restart_rerun");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL restart err_after: got %b expected 0", err);
    end
    drain("restart");
    ws_addr = 20'hFFFFF; ws_n = 0;
  endtask

  task automatic test_reset_mid_boot();
    err_mask = '0; ws_addr = 20'h00004; ws_n = 5;
    apply_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (apbm_if.paddr !== 20'h00004 || apbm_if.penable !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset pre: got addr=%h pen=%b expected 00004 1", apbm_if.paddr, apbm_if.penable);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (apbm_if.psel !== 1'b0 || apbm_if.penable !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset immediate: got psel=%b pen=%b done=%b expected 0 0 0",
               apbm_if.psel, apbm_if.penable, done);
    end
    while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
    drain("mid_reset_before");
    push_boot();
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(7 + 5, "mid_reset_after");
    drain("mid_reset_after");
    ws_addr = 20'hFFFFF; ws_n = 0;
  endtask

  initial begin
    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b0;
    apbs_if.paddr = '0; apbs_if.pwdata = '0;
    test_reset();
    test_boot_zero_ws();
    test_wait_states();
    test_error_capture();
    test_fabric_during_boot();
    test_restart();
    test_reset_mid_boot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
